// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for base^exponent mod modulus.
// Every reduction is handed to the shared 64-bit iterative modulo unit through its ld/done handshake.
module modexp_ctrl #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic                 mod_ld,
  output logic [63:0]          mod_a,
  output logic [63:0]          mod_b,
  input  logic [63:0]          mod_o,
  input  logic                 mod_done
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RED_ISSUE = 4'd1;
  localparam logic [3:0] RED_WAIT  = 4'd2;
  localparam logic [3:0] CHECK     = 4'd3;
  localparam logic [3:0] MUL_ISSUE = 4'd4;
  localparam logic [3:0] MUL_WAIT  = 4'd5;
  localparam logic [3:0] SHIFT     = 4'd6;
  localparam logic [3:0] SQR_ISSUE = 4'd7;
  localparam logic [3:0] SQR_WAIT  = 4'd8;
  localparam logic [3:0] FINISH    = 4'd9;

  logic [3:0]           state;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     r;
  logic [WIDTH-1:0]     b;
  logic [EXP_WIDTH-1:0] e;
  logic [63:0]          rx;
  logic [63:0]          bx;
  logic                 unused_modo;

  // WIDTH <= 32 keeps every r*b or b*b product inside the 64-bit dividend.
  assign rx = 64'(r);
  assign bx = 64'(b);
  assign unused_modo = ^mod_o[63:WIDTH];

  // b holds the latched base until its first reduction, then the running square.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      n      <= '0;
      r      <= '0;
      b      <= '0;
      e      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      mod_ld <= 1'b0;
      mod_a  <= '0;
      mod_b  <= '0;
    end else begin
      mod_ld <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n    <= modulus;
            e    <= exponent;
            b    <= base;
            err  <= 1'b0;
            busy <= 1'b1;
            if (modulus == '0) begin
              err   <= 1'b1;
              r     <= '0;
              state <= FINISH;
            end else if (modulus == WIDTH'(1)) begin
              r     <= '0;
              state <= FINISH;
            end else if (exponent == '0) begin
              r     <= WIDTH'(1);
              state <= FINISH;
            end else begin
              r     <= WIDTH'(1);
              state <= RED_ISSUE;
            end
          end
        end
        RED_ISSUE: begin
          mod_ld <= 1'b1;
          mod_a  <= bx;
          mod_b  <= 64'(n);
          state  <= RED_WAIT;
        end
        RED_WAIT: begin
          if (mod_done) begin
            b     <= mod_o[WIDTH-1:0];
            state <= CHECK;
          end
        end
        CHECK: begin
          state <= e[0] ? MUL_ISSUE : SHIFT;
        end
        MUL_ISSUE: begin
          mod_ld <= 1'b1;
          mod_a  <= rx * bx;
          state  <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mod_done) begin
            r     <= mod_o[WIDTH-1:0];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          e <= e >> 1;
          // The square after the last exponent bit would never be used, so skip it.
          if ((e >> 1) == '0) state <= FINISH;
          else                state <= SQR_ISSUE;
        end
        SQR_ISSUE: begin
          mod_ld <= 1'b1;
          mod_a  <= bx * bx;
          state  <= SQR_WAIT;
        end
        SQR_WAIT: begin
          if (mod_done) begin
            b     <= mod_o[WIDTH-1:0];
            state <= CHECK;
          end
        end
        FINISH: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          result <= r;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl: a behavioural modulo unit answers each load,
// and a monitor compares every done pulse against a plain-arithmetic reference.
module tb_modexp_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] exponent = '0;
  logic [31:0] modulus = '0;
  logic        busy, done, err, mod_ld;
  logic [31:0] result;
  logic [63:0] mod_a, mod_b;
  logic [63:0] mod_o = '0;
  logic        mod_done = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lds;
    bit          degen;
    int          startCyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ldCount = 0;
  bit   spurious = 0;
  bit   idleSpur = 0;
  bit   fixedLat = 0;

  modexp_ctrl #(.WIDTH(32), .EXP_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
    .mod_ld(mod_ld), .mod_a(mod_a), .mod_b(mod_b), .mod_o(mod_o), .mod_done(mod_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refModExp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    longint unsigned acc, sq, nn;
    logic [31:0] ee;
    if (n < 2) return 32'd0;
    nn  = 64'(n);
    acc = 1;
    sq  = 64'(b) % nn;
    ee  = e;
    while (ee != 0) begin
      if (ee[0]) acc = (acc * sq) % nn;
      sq = (sq * sq) % nn;
      ee = ee >> 1;
    end
    return acc[31:0];
  endfunction

  function automatic int refLds(input logic [31:0] e, input logic [31:0] n);
    int bitLen;
    if (n < 2 || e == 0) return 0;
    bitLen = 0;
    for (int i = 0; i < 32; i++) if (e[i]) bitLen = i + 1;
    return 1 + $countones(e) + bitLen - 1;
  endfunction

  task automatic waitIdle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) checkOutput("idle timeout", busy, 0);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    exp_t x;
    waitIdle();
    x.res      = refModExp(b, e, n);
    x.err      = (n == 0);
    x.lds      = refLds(e, n);
    x.degen    = (n < 2 || e == 0);
    x.startCyc = cyc;
    base = b; exponent = e; modulus = n; start = 1'b1; ldCount = 0;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    base = $urandom; exponent = $urandom; modulus = $urandom;
  endtask

  // Behavioural modulo unit with a random latency; also checks operand hold and ld discipline.
  initial begin : modModel
    logic [63:0] a, d;
    bit ok, aborted;
    int lat;
    forever begin
      @(negedge clk);
      if (idleSpur) begin
        mod_o = 64'h1234_5678_9abc_def0; mod_done = 1'b1;
        @(negedge clk);
        mod_done = 1'b0; mod_o = '0; idleSpur = 0;
      end else if (!rst && mod_ld === 1'b1) begin
        a = mod_a; d = mod_b; ok = 1; aborted = 0;
        lat = fixedLat ? 6 : int'($urandom_range(1, 6));
        ldCount++;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst) begin aborted = 1; break; end
          if (mod_a !== a || mod_b !== d || mod_ld !== 1'b0) ok = 0;
        end
        if (!aborted) begin
          mod_o = (d == 0) ? 64'd0 : a % d;
          mod_done = 1'b1;
          @(negedge clk);
          if (mod_a !== a || mod_b !== d) ok = 0;
          checkOutput("operand hold", 64'(ok), 1);
          if (spurious) begin
            mod_o = 64'hffff_ffff_ffff_ffff;
            @(negedge clk);
          end
        end
        mod_done = 1'b0; mod_o = '0;
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) checkOutput("unexpected done", 64'(done), 0);
        else begin
          x = sb.pop_front();
          checkOutput("result", result, x.res);
          checkOutput("err", err, x.err);
          checkOutput("ld count", ldCount, x.lds);
          checkOutput("busy at done", busy, 0);
          if (x.degen) checkOutput("latency", cyc - x.startCyc, 2);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : mainSeq
    int k;
    logic [31:0] rb, re, rn;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset mod_ld", mod_ld, 0);
    checkOutput("reset mod_a", mod_a, 0);
    checkOutput("reset mod_b", mod_b, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'd4, 32'd13, 32'd497);
    applyStimulus(32'd2, 32'd10, 32'd1000);
    applyStimulus(32'd1000, 32'd1, 32'd7);
    applyStimulus(32'd9, 32'd3, 32'd0);
    applyStimulus(32'd9, 32'd3, 32'd1);
    applyStimulus(32'd5, 32'd0, 32'd11);

    // Spurious mod_done while idle, then a restart attempt and spurious done mid-run.
    waitIdle();
    idleSpur = 1;
    repeat (4) @(negedge clk);
    spurious = 1;
    applyStimulus(32'd3, 32'd5, 32'd13);
    repeat (4) @(negedge clk);
    base = 32'd7; exponent = 32'd9; modulus = 32'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    spurious = 0;

    // Reset while the first multiply is outstanding: outputs clear at once, no done follows.
    fixedLat = 1;
    base = 32'd4; exponent = 32'd13; modulus = 32'd497; start = 1'b1; ldCount = 0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (ldCount < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("reached mul wait", 64'(ldCount), 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset flags", {busy, done, err, mod_ld}, 0);
    checkOutput("async reset result", result, 0);
    checkOutput("async reset mod_a", mod_a, 0);
    checkOutput("async reset mod_b", mod_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fixedLat = 0;
    repeat (10) @(negedge clk);
    applyStimulus(32'd4, 32'd13, 32'd497);

    for (int i = 0; i < 25; i++) begin
      rb = $urandom;
      case ($urandom_range(0, 9))
        0:       rn = 32'd0;
        1:       rn = 32'd1;
        2, 3:    rn = $urandom_range(2, 40);
        default: rn = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       re = 32'd0;
        1, 2:    re = $urandom_range(1, 64);
        default: re = $urandom;
      endcase
      applyStimulus(rb, re, rn);
    end

    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer that computes result = base^exponent mod modulus using right-to-left binary square-and-multiply.
- Forms each 2*WIDTH-bit product internally and sends every reduction to the shared 64-bit iterative modulo unit through its ld/Done handshake.
- Sits between the RSA key/message registers and the modulo unit, and is the unit's only requester.

Parameters:
- WIDTH, 32, width of base, modulus and result; must satisfy WIDTH <= 32 so that a product fits the 64-bit modulo operand.
- EXP_WIDTH, 32, width of exponent.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- base  in  WIDTH  message/base operand; sampled when start is accepted.
- exponent  in  EXP_WIDTH  exponent; sampled when start is accepted.
- modulus  in  WIDTH  modulus N; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  set when modulus==0; cleared by the next accepted start.
- result  out  WIDTH  final value; held until the next accepted start.
- mod_ld  out  1  one-cycle load strobe to the modulo unit.
- mod_a  out  64  dividend to the modulo unit, zero-extended.
- mod_b  out  64  divisor to the modulo unit, zero-extended N.
- mod_o  in  64  remainder from the modulo unit; valid while mod_done==1.
- mod_done  in  1  one-cycle completion pulse from the modulo unit.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; internal r, b, e cleared.
- IDLE, start=1: latch N, e=exponent, and the base. Clear err.
  - N==0: err=1, result=0.
  - N==1: result=0.
  - e==0 (N>1): result=1.
  - In these three cases go to FINISH; no mod_ld is issued.
  - Otherwise: r=1, go to RED_ISSUE.
- RED_ISSUE: mod_ld=1, mod_a=base, mod_b=N; go to RED_WAIT.
- RED_WAIT: on mod_done, b = mod_o[WIDTH-1:0]; go to CHECK.
- CHECK:
  - e[0]==1: go to MUL_ISSUE.
  - else: go to SHIFT.
- MUL_ISSUE: mod_ld=1, mod_a = r*b (full 2*WIDTH-bit product); go to MUL_WAIT.
- MUL_WAIT: on mod_done, r = mod_o[WIDTH-1:0]; go to SHIFT.
- SHIFT: e = e>>1.
  - New e==0: go to FINISH, with result=r. The final squaring is skipped.
  - Else: go to SQR_ISSUE.
- SQR_ISSUE: mod_ld=1, mod_a = b*b; go to SQR_WAIT.
- SQR_WAIT: on mod_done, b = mod_o[WIDTH-1:0]; go to CHECK.
- FINISH: done=1 for exactly one cycle, busy=0; go to IDLE. A start is accepted no earlier than the next cycle.
- Modulo handshake rules:
  - mod_ld is high for exactly one cycle per operation.
  - mod_a and mod_b are registered and held stable from the mod_ld cycle through the mod_done cycle.
  - mod_ld is never asserted while an operation is outstanding.
  - The earliest next mod_ld is the cycle after the mod_done that was captured.
- mod_done arriving in any state other than *_WAIT is ignored.
- Operation count for N>1, E>0: exactly 1 + popcount(E) + (bitlen(E)-1) mod_ld pulses.
- Latency for N==0, N==1 or E==0: done is asserted 2 cycles after the start cycle, with zero mod_ld pulses.
- Otherwise latency is the sum of the modulo unit latencies plus a fixed per-operation controller overhead.
- start while busy: ignored; the latched operands are unaffected.
- rst mid-operation: immediate return to IDLE, mod_ld=0, no done pulse. The modulo unit shares rst and is cleared with it.
- Arithmetic: products are unsigned 2*WIDTH-bit values zero-extended to 64 bits. r and b always stay < N after reduction.

Test Plan:
- base=4, E=13, N=497 -> result=445, done pulse once, err=0, exactly 7 mod_ld pulses.
- base=2, E=10, N=1000 -> result=24, 6 mod_ld pulses; mod_a/mod_b stable during each wait.
- base=1000, E=1, N=7 -> result=6, 2 mod_ld pulses, no square issued.
- Degenerate cases:
  - N=0 -> err=1, result=0.
  - N=1 -> result=0.
  - base=5, E=0, N=11 -> result=1.
  - Each: done asserted 2 cycles after start, zero mod_ld.
- start re-pulsed while busy, and a spurious mod_done outside the wait states -> both ignored; base=3, E=5, N=13 still yields result=9.
- rst asserted during MUL_WAIT -> all outputs 0 asynchronously, no done pulse. A new start with base=4, E=13, N=497 then completes with 445.
